// File: rtl/cv32e40p_ft_pkg.sv
// Shared types for the fault-tolerant replica dispatcher: redundancy modes and
// the commit state machine encoding.
package cv32e40p_ft_pkg;

    localparam logic [1:0] FT_MODE_TMR     = 2'b00;
    localparam logic [1:0] FT_MODE_DMR     = 2'b01;
    localparam logic [1:0] FT_MODE_SIMPLEX = 2'b10;
    localparam logic [1:0] FT_MODE_FAILED  = 2'b11;

    typedef enum logic [1:0] {
        MODE_TMR     = FT_MODE_TMR,
        MODE_DMR     = FT_MODE_DMR,
        MODE_SIMPLEX = FT_MODE_SIMPLEX,
        MODE_FAILED  = FT_MODE_FAILED
    } ft_mode_e;

    typedef enum logic {
        ST_STABLE,
        ST_PENDING
    } ft_disp_state_e;

endpackage

// File: rtl/cv32e40p_ft_fault_counter.sv
// Per-replica leaky error counter with a sticky faulty flag; the counter freezes
// once the replica has been declared faulty.
module cv32e40p_ft_fault_counter
    import cv32e40p_ft_pkg::*;
#(
    parameter int CNT_W        = 4,
    parameter int FAULT_THRESH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic faulty_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THRESH  = CNT_W'(FAULT_THRESH);

    logic [CNT_W-1:0] r_cnt;
    logic             r_faulty;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_faulty <= 1'b0;
        end else if (clear_i) begin
            r_cnt    <= '0;
            r_faulty <= 1'b0;
        end else if (!r_faulty) begin
            if (inc_i) begin
                if (r_cnt != CNT_MAX) r_cnt <= w_cnt_inc;
                if (r_cnt != CNT_MAX && w_cnt_inc == THRESH) r_faulty <= 1'b1;
            end else if (dec_i && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign faulty_o = r_faulty;

endmodule

// File: rtl/cv32e40p_replica_dispatcher_ft.sv
// Replica health tracker and voter-slot selector for one functional-unit class;
// degrades TMR -> DMR -> SIMPLEX -> FAILED and commits only while EX is idle.
module cv32e40p_replica_dispatcher_ft
    import cv32e40p_ft_pkg::*;
#(
    parameter  int NUM_UNITS    = 4,
    parameter  int CNT_W        = 4,
    parameter  int FAULT_THRESH = 8,
    parameter  int DECAY_PERIOD = 256,
    localparam int IDX_W        = $clog2(NUM_UNITS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear_faults_i,
    input  logic                   op_valid_i,
    input  logic [NUM_UNITS-1:0]   unit_mismatch_i,
    input  logic                   pipe_idle_i,
    output logic [NUM_UNITS-1:0]   clock_gate_o,
    output logic [3*IDX_W-1:0]     sel_idx_o,
    output logic [1:0]             mode_o,
    output logic [NUM_UNITS-1:0]   permanent_faulty_o,
    output logic                   fault_event_o,
    output logic                   reconfig_pending_o,
    output logic                   totally_defective_o
);

    localparam int PER_W = $clog2(DECAY_PERIOD);
    localparam int HC_W  = IDX_W + 1;
    localparam logic [3*IDX_W-1:0]   SEL_RST  = {IDX_W'(2), IDX_W'(1), IDX_W'(0)};
    localparam logic [NUM_UNITS-1:0] GATE_RST = NUM_UNITS'(3'b111);

    logic [NUM_UNITS-1:0] w_faulty, w_inc, w_dec, w_tgt_gate;
    logic                 w_op, w_wrap, w_differs;
    logic [HC_W-1:0]      w_healthy;
    logic [IDX_W-1:0]     w_s0, w_s1, w_s2;
    ft_mode_e             w_tgt_mode;
    logic [3*IDX_W-1:0]   w_tgt_sel;

    logic [PER_W-1:0]     r_period;
    logic [NUM_UNITS-1:0] r_faulty_q, r_gate;
    logic [3*IDX_W-1:0]   r_sel;
    ft_mode_e             r_mode;
    ft_disp_state_e       r_state;
    logic                 r_pending;

    assign w_op   = op_valid_i && (r_mode != MODE_FAILED);
    assign w_wrap = w_op && (r_period == PER_W'(DECAY_PERIOD - 1));
    assign w_inc  = {NUM_UNITS{w_op}} & unit_mismatch_i & r_gate & ~w_faulty;
    assign w_dec  = {NUM_UNITS{w_wrap}} & ~w_inc;

    generate
        for (genvar k = 0; k < NUM_UNITS; k++) begin : g_unit
            cv32e40p_ft_fault_counter #(
                .CNT_W        (CNT_W),
                .FAULT_THRESH (FAULT_THRESH)
            ) u_cnt (
                .clk      (clk),
                .rst      (rst),
                .clear_i  (clear_faults_i),
                .inc_i    (w_inc[k]),
                .dec_i    (w_dec[k]),
                .faulty_o (w_faulty[k])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_period   <= '0;
            r_faulty_q <= '0;
        end else begin
            r_faulty_q <= w_faulty;
            if (clear_faults_i || w_wrap) r_period <= '0;
            else if (w_op)                r_period <= r_period + 1'b1;
        end
    end

    // NOTE: every combinational output gets a default before the loop so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_healthy  = '0;
        w_s0       = '0;
        w_s1       = '0;
        w_s2       = '0;
        w_tgt_gate = '0;
        w_tgt_mode = MODE_FAILED;
        w_tgt_sel  = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (!w_faulty[k]) begin
                if (w_healthy == HC_W'(0))      w_s0 = IDX_W'(k);
                else if (w_healthy == HC_W'(1)) w_s1 = IDX_W'(k);
                else if (w_healthy == HC_W'(2)) w_s2 = IDX_W'(k);
                if (w_healthy < HC_W'(3)) w_tgt_gate[k] = 1'b1;
                w_healthy = w_healthy + 1'b1;
            end
        end
        if (w_healthy >= HC_W'(3)) begin
            w_tgt_mode = MODE_TMR;
            w_tgt_sel  = {w_s2, w_s1, w_s0};
        end else if (w_healthy == HC_W'(2)) begin
            w_tgt_mode = MODE_DMR;
            w_tgt_sel  = {w_s1, w_s1, w_s0};
        end else if (w_healthy == HC_W'(1)) begin
            w_tgt_mode = MODE_SIMPLEX;
            w_tgt_sel  = {w_s0, w_s0, w_s0};
        end
    end

    assign w_differs = (w_tgt_mode != r_mode) || (w_tgt_sel != r_sel) || (w_tgt_gate != r_gate);

    // Whatever target is present when the pipe drains is the one committed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_STABLE;
            r_pending <= 1'b0;
            r_mode    <= MODE_TMR;
            r_sel     <= SEL_RST;
            r_gate    <= GATE_RST;
        end else begin
            case (r_state)
                ST_STABLE: begin
                    if (w_differs) begin
                        r_state   <= ST_PENDING;
                        r_pending <= 1'b1;
                    end
                end
                ST_PENDING: begin
                    if (!w_differs) begin
                        r_state   <= ST_STABLE;
                        r_pending <= 1'b0;
                    end else if (pipe_idle_i) begin
                        r_state   <= ST_STABLE;
                        r_pending <= 1'b0;
                        r_mode    <= w_tgt_mode;
                        r_sel     <= w_tgt_sel;
                        r_gate    <= w_tgt_gate;
                    end
                end
                default: begin
                    r_state   <= ST_STABLE;
                    r_pending <= 1'b0;
                end
            endcase
        end
    end

    assign clock_gate_o        = r_gate;
    assign sel_idx_o           = r_sel;
    assign mode_o              = r_mode;
    assign permanent_faulty_o  = w_faulty;
    assign fault_event_o       = |(w_faulty & ~r_faulty_q);
    assign reconfig_pending_o  = r_pending;
    assign totally_defective_o = (r_mode == MODE_FAILED);

endmodule
